// File: rtl/reg_ctx_engine_if.sv
// Bundles the control, register-file and stream signals of reg_ctx_engine.
// The master modport is the engine side; the slave modport is its environment.
interface reg_ctx_engine_if;
  logic       START;
  logic       MODE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [2:0] RF_OUT1ADDRESS;
  logic [7:0] RF_OUT1;
  logic [2:0] RF_INADDRESS;
  logic [7:0] RF_IN;
  logic       RF_WRITE;
  logic [7:0] S_DATA;
  logic       S_VALID;
  logic       S_READY;
  logic [7:0] L_DATA;
  logic       L_VALID;
  logic       L_READY;

  modport master (
    input  START, MODE, RF_OUT1, S_READY, L_DATA, L_VALID,
    output BUSY, DONE, ERR, RF_OUT1ADDRESS, RF_INADDRESS, RF_IN, RF_WRITE,
           S_DATA, S_VALID, L_READY
  );

  modport slave (
    output START, MODE, RF_OUT1, S_READY, L_DATA, L_VALID,
    input  BUSY, DONE, ERR, RF_OUT1ADDRESS, RF_INADDRESS, RF_IN, RF_WRITE,
           S_DATA, S_VALID, L_READY
  );
endinterface

// File: rtl/reg_ctx_engine.sv
// Saves registers 0..LAST_REG to a byte stream, or restores them from one.
// Optional macro REG_CTX_CHECKSUM_EN appends/verifies an XOR checksum byte.
module reg_ctx_engine #(
  parameter int LAST_REG = 7
) (
  input logic              CLK,
  input logic              RESET,
  reg_ctx_engine_if.master bus
);

  localparam logic [2:0] LAST_IDX = 3'(LAST_REG);

`ifdef REG_CTX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SAVE_ADDR,
    SAVE_SEND,
    LOAD_RECV,
    FINISH
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [7:0] s_data;
  logic [7:0] acc;
  logic       csum_phase;
  logic       err_q;
  logic       done_q;
  logic       busy_q;
  logic       s_valid_q;
  logic       l_ready_q;

  logic       at_last;
  logic       s_fire;

  assign at_last = (idx == LAST_IDX);
  assign s_fire  = s_valid_q & bus.S_READY;

  // Handshake strobes are masked by RESET so nothing completes in a reset cycle.
  assign bus.BUSY           = busy_q;
  assign bus.DONE           = done_q;
  assign bus.ERR            = CSUM_EN ? err_q : 1'b0;
  assign bus.RF_OUT1ADDRESS = idx;
  assign bus.RF_INADDRESS   = idx;
  assign bus.RF_IN          = (l_ready_q & ~RESET) ? bus.L_DATA : 8'h00;
  assign bus.RF_WRITE       = l_ready_q & ~csum_phase & bus.L_VALID & ~RESET;
  assign bus.L_READY        = l_ready_q & ~RESET;
  assign bus.S_VALID        = s_valid_q & ~RESET;
  assign bus.S_DATA         = s_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      idx        <= 3'd0;
      s_data     <= 8'h00;
      acc        <= 8'h00;
      csum_phase <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      s_valid_q  <= 1'b0;
      l_ready_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            idx        <= 3'd0;
            err_q      <= 1'b0;
            acc        <= 8'h00;
            csum_phase <= 1'b0;
            busy_q     <= 1'b1;
            if (bus.MODE) begin
              l_ready_q <= 1'b1;
              state     <= LOAD_RECV;
            end else begin
              state     <= SAVE_ADDR;
            end
          end
        end

        SAVE_ADDR: begin
          s_data    <= bus.RF_OUT1;
          s_valid_q <= 1'b1;
          state     <= SAVE_SEND;
        end

        // The checksum byte reuses SAVE_SEND directly; no register read is needed for it.
        SAVE_SEND: begin
          if (s_fire) begin
            acc <= acc ^ s_data;
            if (csum_phase || (at_last && !CSUM_EN)) begin
              s_valid_q <= 1'b0;
              done_q    <= 1'b1;
              state     <= FINISH;
            end else if (at_last) begin
              csum_phase <= 1'b1;
              s_data     <= acc ^ s_data;
            end else begin
              idx       <= idx + 3'd1;
              s_valid_q <= 1'b0;
              state     <= SAVE_ADDR;
            end
          end
        end

        LOAD_RECV: begin
          if (bus.L_VALID) begin
            if (csum_phase) begin
              err_q     <= (bus.L_DATA != acc);
              l_ready_q <= 1'b0;
              done_q    <= 1'b1;
              state     <= FINISH;
            end else begin
              acc <= acc ^ bus.L_DATA;
              if (at_last) begin
                if (CSUM_EN) begin
                  csum_phase <= 1'b1;
                end else begin
                  l_ready_q <= 1'b0;
                  done_q    <= 1'b1;
                  state     <= FINISH;
                end
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end
        end

        FINISH: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          busy_q    <= 1'b0;
          s_valid_q <= 1'b0;
          l_ready_q <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_ctx_engine.sv
// Randomized self-checking bench for reg_ctx_engine with a behavioural register file
// and stream model; checksum expectations follow REG_CTX_CHECKSUM_EN.
module tb_reg_ctx_engine;
  localparam int LAST = 7;
  localparam int NREG = LAST + 1;
`ifdef REG_CTX_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  reg_ctx_engine_if bus();

  reg_ctx_engine #(.LAST_REG(LAST)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [7:0] rf      [8];
  logic [7:0] preload [8];
  logic       preload_en = 1'b0;

  // Behavioural register file: writes on the posedge where RF_WRITE is high.
  always @(posedge CLK) begin
    if (preload_en) begin
      for (int i = 0; i < 8; i++) rf[i] <= preload[i];
    end else if (bus.RF_WRITE) begin
      rf[bus.RF_INADDRESS] <= bus.RF_IN;
    end
  end
  assign bus.RF_OUT1 = rf[bus.RF_OUT1ADDRESS];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] xor_of(input logic [7:0] q[$]);
    logic [7:0] x = 8'h00;
    foreach (q[i]) x ^= q[i];
    return x;
  endfunction

  function automatic void expect_stream(input logic [7:0] regs[8], output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < NREG; i++) q.push_back(regs[i]);
`ifdef REG_CTX_CHECKSUM_EN
    q.push_back(xor_of(q));
`endif
  endfunction

  task automatic load_rf(input logic [7:0] vals[8]);
    @(negedge CLK);
    preload    = vals;
    preload_en = 1'b1;
    @(negedge CLK);
    preload_en = 1'b0;
  endtask

  task automatic do_save(input int stall_at, input int stall_len, input bit rand_ready,
                         input bit poke_start, output logic [7:0] got[$], output int done_at,
                         output int done_pulses, output int hold_errs, output bit timeout);
    int         cyc;
    int         stalls;
    bit         prev_stall;
    bit         ready;
    bit         finished;
    logic [7:0] prev_data;
    got = {}; done_at = -1; done_pulses = 0; hold_errs = 0; timeout = 0;
    stalls = 0; prev_stall = 0; prev_data = 8'h00; finished = 0;
    @(negedge CLK);
    bus.START = 1'b1; bus.MODE = 1'b0; bus.S_READY = 1'b0;
    @(posedge CLK);
    cyc = 0;
    while (!finished) begin
      @(negedge CLK);
      bus.START = 1'b0; bus.MODE = 1'b0;
      if (poke_start && cyc == 5) begin bus.START = 1'b1; bus.MODE = 1'b1; end
      if (bus.DONE) begin done_pulses++; if (done_at < 0) done_at = cyc; end
      if (prev_stall && (bus.S_VALID !== 1'b1 || bus.S_DATA !== prev_data)) hold_errs++;
      if (rand_ready) ready = ($urandom_range(0, 1) == 1);
      else if (bus.S_VALID && got.size() == stall_at && stalls < stall_len) begin
        ready = 1'b0; stalls++;
      end else ready = 1'b1;
      bus.S_READY = ready;
      if (bus.S_VALID && ready) got.push_back(bus.S_DATA);
      prev_stall = bus.S_VALID && !ready;
      prev_data  = bus.S_DATA;
      if (cyc > 0 && !bus.BUSY) finished = 1;
      else if (cyc >= 400) begin timeout = 1; finished = 1; end
      @(posedge CLK);
      cyc++;
    end
    bus.S_READY = 1'b0;
  endtask

  task automatic do_restore(input logic [7:0] data[$], input bit rand_valid,
                            output logic [10:0] wlog[$], output int wcyc[$], output int done_at,
                            output int done_pulses, output logic err_fin, output bit timeout);
    int cyc;
    int ptr;
    bit v;
    bit finished;
    wlog = {}; wcyc = {}; done_at = -1; done_pulses = 0; err_fin = 1'b0; timeout = 0;
    ptr = 0; finished = 0;
    @(negedge CLK);
    bus.START = 1'b1; bus.MODE = 1'b1; bus.L_VALID = 1'b0;
    @(posedge CLK);
    cyc = 0;
    while (!finished) begin
      @(negedge CLK);
      bus.START = 1'b0;
      if (bus.DONE) begin
        done_pulses++;
        if (done_at < 0) begin done_at = cyc; err_fin = bus.ERR; end
      end
      v = (ptr < data.size()) && (!rand_valid || $urandom_range(0, 1) == 1);
      bus.L_VALID = v;
      bus.L_DATA  = v ? data[ptr] : 8'($urandom);
      #1;
      if (bus.RF_WRITE) begin
        wlog.push_back({bus.RF_INADDRESS, bus.RF_IN});
        wcyc.push_back(cyc);
      end
      if (v && bus.L_READY) ptr++;
      if (cyc > 0 && !bus.BUSY) finished = 1;
      else if (cyc >= 400) begin timeout = 1; finished = 1; end
      @(posedge CLK);
      cyc++;
    end
    bus.L_VALID = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] z [8];
    foreach (z[i]) z[i] = 8'h00;
    RESET = 1'b1;
    load_rf(z);
    @(negedge CLK);
    checks += 10;
    if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", bus.DONE); end
    if (bus.ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b, expected 0", bus.ERR); end
    if (bus.S_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_valid: got %b, expected 0", bus.S_VALID); end
    if (bus.L_READY !== 1'b0) begin errors++; $display("[TB] FAIL reset_l_ready: got %b, expected 0", bus.L_READY); end
    if (bus.RF_WRITE !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_write: got %b, expected 0", bus.RF_WRITE); end
    if (bus.RF_OUT1ADDRESS !== 3'd0) begin errors++; $display("[TB] FAIL reset_out1addr: got %0d, expected 0", bus.RF_OUT1ADDRESS); end
    if (bus.RF_INADDRESS !== 3'd0) begin errors++; $display("[TB] FAIL reset_inaddr: got %0d, expected 0", bus.RF_INADDRESS); end
    if (bus.RF_IN !== 8'h00) begin errors++; $display("[TB] FAIL reset_rf_in: got %h, expected 00", bus.RF_IN); end
    if (bus.S_DATA !== 8'h00) begin errors++; $display("[TB] FAIL reset_s_data: got %h, expected 00", bus.S_DATA); end
    RESET = 1'b0;
  endtask

  task automatic test_save_basic();
    logic [7:0] regs [8];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    int         done_at, pulses, hold_errs;
    bit         to;
    foreach (regs[i]) regs[i] = 8'(i);
    load_rf(regs);
    expect_stream(regs, exp);
    do_save(-1, 0, 1'b0, 1'b0, got, done_at, pulses, hold_errs, to);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL save_basic_timeout: got timeout, expected completion"); end
    if (got.size() != exp.size()) begin errors++; $display("[TB] FAIL save_basic_count: got %0d bytes, expected %0d", got.size(), exp.size()); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL save_basic_done: got %0d pulses, expected 1", pulses); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 8'hxx) !== exp[i]) begin
        errors++; $display("[TB] FAIL save_basic_byte%0d: got %h, expected %h", i, (i < got.size() ? got[i] : 8'hxx), exp[i]);
      end
    end
`ifndef REG_CTX_CHECKSUM_EN
    checks++;
    if (done_at != 2 * NREG) begin errors++; $display("[TB] FAIL save_basic_cycles: got %0d, expected %0d", done_at, 2 * NREG); end
`endif
  endtask

  task automatic test_save_stall();
    logic [7:0] regs [8];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    int         done_at, pulses, hold_errs;
    bit         to;
    foreach (regs[i]) regs[i] = 8'(i);
    load_rf(regs);
    expect_stream(regs, exp);
    do_save(2, 3, 1'b0, 1'b0, got, done_at, pulses, hold_errs, to);
    checks += 4;
    if (to) begin errors++; $display("[TB] FAIL save_stall_timeout: got timeout, expected completion"); end
    if (hold_errs != 0) begin errors++; $display("[TB] FAIL save_stall_hold: got %0d unstable cycles, expected 0", hold_errs); end
    if (got.size() != exp.size()) begin errors++; $display("[TB] FAIL save_stall_count: got %0d bytes, expected %0d", got.size(), exp.size()); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL save_stall_done: got %0d pulses, expected 1", pulses); end
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if ((i < got.size() ? got[i] : 8'hxx) !== exp[i]) begin
        errors++; $display("[TB] FAIL save_stall_byte%0d: got %h, expected %h", i, (i < got.size() ? got[i] : 8'hxx), exp[i]);
      end
    end
`ifndef REG_CTX_CHECKSUM_EN
    checks++;
    if (done_at != 2 * NREG + 3) begin errors++; $display("[TB] FAIL save_stall_cycles: got %0d, expected %0d", done_at, 2 * NREG + 3); end
`endif
  endtask

  task automatic test_save_start_ignored();
    logic [7:0] regs [8];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    int         done_at, pulses, hold_errs;
    bit         to;
    foreach (regs[i]) regs[i] = 8'($urandom);
    load_rf(regs);
    expect_stream(regs, exp);
    do_save(-1, 0, 1'b0, 1'b1, got, done_at, pulses, hold_errs, to);
    checks += 4;
    if (to) begin errors++; $display("[TB] FAIL start_ignored_timeout: got timeout, expected completion"); end
    if (got.size() != exp.size()) begin errors++; $display("[TB] FAIL start_ignored_count: got %0d bytes, expected %0d", got.size(), exp.size()); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL start_ignored_done: got %0d pulses, expected 1", pulses); end
    if (got != exp) begin errors++; $display("[TB] FAIL start_ignored_data: got %p, expected %p", got, exp); end
  endtask

  task automatic test_restore_basic();
    logic [7:0]  data[$];
    logic [10:0] wlog[$];
    int          wcyc[$];
    int          done_at, pulses;
    logic        err_fin;
    bit          to;
    for (int i = 0; i < NREG; i++) data.push_back(8'hA0 + 8'(i));
`ifdef REG_CTX_CHECKSUM_EN
    data.push_back(xor_of(data));
`endif
    do_restore(data, 1'b0, wlog, wcyc, done_at, pulses, err_fin, to);
    checks += 5;
    if (to) begin errors++; $display("[TB] FAIL restore_basic_timeout: got timeout, expected completion"); end
    if (wlog.size() != NREG) begin errors++; $display("[TB] FAIL restore_basic_writes: got %0d, expected %0d", wlog.size(), NREG); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL restore_basic_done: got %0d pulses, expected 1", pulses); end
    if (done_at != NREG + CSUM) begin errors++; $display("[TB] FAIL restore_basic_done_cycle: got %0d, expected %0d", done_at, NREG + CSUM); end
    if (err_fin !== 1'b0) begin errors++; $display("[TB] FAIL restore_basic_err: got %b, expected 0", err_fin); end
    for (int i = 0; i < NREG; i++) begin
      checks += 3;
      if ((i < wlog.size() ? wlog[i] : 11'hx) !== {3'(i), 8'hA0 + 8'(i)}) begin
        errors++; $display("[TB] FAIL restore_basic_write%0d: got %h, expected %h", i, (i < wlog.size() ? wlog[i] : 11'hx), {3'(i), 8'hA0 + 8'(i)});
      end
      if ((i < wcyc.size() ? wcyc[i] : -1) != i) begin
        errors++; $display("[TB] FAIL restore_basic_wcycle%0d: got %0d, expected %0d", i, (i < wcyc.size() ? wcyc[i] : -1), i);
      end
      if (rf[i] !== 8'hA0 + 8'(i)) begin
        errors++; $display("[TB] FAIL restore_basic_reg%0d: got %h, expected %h", i, rf[i], 8'hA0 + 8'(i));
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] regs [8];
    logic [7:0] b [8];
    logic [7:0] exp_regs [8];
    logic [7:0] exp[$];
    logic [7:0] got[$];
    int         done_seen, done_at, pulses, hold_errs;
    bit         to;
    foreach (regs[i]) regs[i] = 8'h55;
    foreach (b[i]) b[i] = 8'($urandom);
    load_rf(regs);
    @(negedge CLK);
    bus.START = 1'b1; bus.MODE = 1'b1; bus.L_VALID = 1'b0;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      bus.L_VALID = 1'b1; bus.L_DATA = b[k];
      @(posedge CLK);
    end
    @(negedge CLK);
    bus.L_DATA = b[3];
    RESET = 1'b1;
    #1;
    checks += 2;
    if (bus.RF_WRITE !== 1'b0) begin errors++; $display("[TB] FAIL abort_rf_write_forced: got %b, expected 0", bus.RF_WRITE); end
    if (bus.L_READY !== 1'b0) begin errors++; $display("[TB] FAIL abort_l_ready_forced: got %b, expected 0", bus.L_READY); end
    @(negedge CLK);
    RESET = 1'b0; bus.L_VALID = 1'b0;
    checks += 2;
    if (bus.BUSY !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b, expected 0", bus.BUSY); end
    if (bus.DONE !== 1'b0) begin errors++; $display("[TB] FAIL abort_done: got %b, expected 0", bus.DONE); end
    done_seen = 0;
    repeat (5) begin @(negedge CLK); if (bus.DONE) done_seen++; end
    checks++;
    if (done_seen != 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d pulses, expected 0", done_seen); end
    foreach (exp_regs[i]) exp_regs[i] = (i < 3) ? b[i] : 8'h55;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rf[i] !== exp_regs[i]) begin errors++; $display("[TB] FAIL abort_reg%0d: got %h, expected %h", i, rf[i], exp_regs[i]); end
    end
    expect_stream(exp_regs, exp);
    do_save(-1, 0, 1'b0, 1'b0, got, done_at, pulses, hold_errs, to);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL abort_resave_timeout: got timeout, expected completion"); end
    if (pulses != 1) begin errors++; $display("[TB] FAIL abort_resave_done: got %0d pulses, expected 1", pulses); end
    if (got != exp) begin errors++; $display("[TB] FAIL abort_resave_data: got %p, expected %p", got, exp); end
  endtask

  task automatic test_checksum();
    logic [7:0]  data[$];
    logic [10:0] wlog[$];
    int          wcyc[$];
    int          done_at, pulses;
    logic        err_fin;
    bit          to;
    for (int i = 0; i < NREG; i++) data.push_back(8'(i + 1));
`ifdef REG_CTX_CHECKSUM_EN
    data.push_back(8'h08);
`endif
    do_restore(data, 1'b0, wlog, wcyc, done_at, pulses, err_fin, to);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL csum_good_timeout: got timeout, expected completion"); end
    if (err_fin !== 1'b0) begin errors++; $display("[TB] FAIL csum_good_err: got %b, expected 0", err_fin); end
    if (wlog.size() != NREG) begin errors++; $display("[TB] FAIL csum_good_writes: got %0d, expected %0d", wlog.size(), NREG); end
`ifdef REG_CTX_CHECKSUM_EN
    data[NREG] = 8'h09;
    do_restore(data, 1'b0, wlog, wcyc, done_at, pulses, err_fin, to);
    checks += 3;
    if (to) begin errors++; $display("[TB] FAIL csum_bad_timeout: got timeout, expected completion"); end
    if (err_fin !== 1'b1) begin errors++; $display("[TB] FAIL csum_bad_err: got %b, expected 1", err_fin); end
    @(negedge CLK);
    if (bus.ERR !== 1'b1) begin errors++; $display("[TB] FAIL csum_bad_sticky: got %b, expected 1", bus.ERR); end
`else
    @(negedge CLK);
    checks++;
    if (bus.ERR !== 1'b0) begin errors++; $display("[TB] FAIL csum_off_err: got %b, expected 0", bus.ERR); end
`endif
  endtask

  task automatic test_random();
    logic [7:0]  regs [8];
    logic [7:0]  exp[$];
    logic [7:0]  got[$];
    logic [7:0]  data[$];
    logic [10:0] wlog[$];
    int          wcyc[$];
    int          done_at, pulses, hold_errs;
    logic        err_fin;
    bit          to;
    for (int r = 0; r < 4; r++) begin
      foreach (regs[i]) regs[i] = 8'($urandom);
      load_rf(regs);
      expect_stream(regs, exp);
      do_save(-1, 0, 1'b1, 1'b0, got, done_at, pulses, hold_errs, to);
      checks += 3;
      if (to) begin errors++; $display("[TB] FAIL rand%0d_save_timeout: got timeout, expected completion", r); end
      if (pulses != 1) begin errors++; $display("[TB] FAIL rand%0d_save_done: got %0d, expected 1", r, pulses); end
      if (got != exp) begin errors++; $display("[TB] FAIL rand%0d_save_data: got %p, expected %p", r, got, exp); end

      data = {};
      for (int i = 0; i < NREG; i++) data.push_back(8'($urandom));
`ifdef REG_CTX_CHECKSUM_EN
      data.push_back(xor_of(data));
`endif
      do_restore(data, 1'b1, wlog, wcyc, done_at, pulses, err_fin, to);
      checks += 4;
      if (to) begin errors++; $display("[TB] FAIL rand%0d_load_timeout: got timeout, expected completion", r); end
      if (pulses != 1) begin errors++; $display("[TB] FAIL rand%0d_load_done: got %0d, expected 1", r, pulses); end
      if (err_fin !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_load_err: got %b, expected 0", r, err_fin); end
      if (wlog.size() != NREG) begin errors++; $display("[TB] FAIL rand%0d_load_writes: got %0d, expected %0d", r, wlog.size(), NREG); end
      for (int i = 0; i < NREG; i++) begin
        checks++;
        if (rf[i] !== data[i]) begin errors++; $display("[TB] FAIL rand%0d_reg%0d: got %h, expected %h", r, i, rf[i], data[i]); end
      end
    end
  endtask

  initial begin
    RESET = 1'b1;
    bus.START = 1'b0; bus.MODE = 1'b0; bus.S_READY = 1'b0;
    bus.L_VALID = 1'b0; bus.L_DATA = 8'h00;
    test_reset();
    test_save_basic();
    test_save_stall();
    test_save_start_ignored();
    test_restore_basic();
    test_reset_abort();
    test_checksum();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
